barrido_teclado: RTL
====================

# barrido_teclado

Parametrised keypad matrix scanner, the successor to the fixed 4-column `barrido` sweep. It drives one-cold column strobes with a programmable dwell and reads synchronised row lines. A key press is debounced over several scan samples, then reported as a linear key code with a one-cycle valid pulse and a held level. It sits between the keypad pins and the input-decoding logic.

## Interface
- `COLS`, 4: number of column strobes, at least 2.
- `ROWS`, 4: number of row inputs, at least 1.
- `SCAN_DIV`, 135: clock cycles each column dwells, at least 4.
- `DEBOUNCE`, 4: consecutive consistent samples needed to accept a press or a release, at least 1.
- `clk`  in  1: single clock; every register is clocked on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `row_i`  in  ROWS: keypad rows, active-low (external pull-ups), asynchronous to `clk`.
- `col_o`  out  COLS: column strobes, one-cold (exactly one bit low), registered.
- `key_code`  out  $clog2(ROWS*COLS): code of the held key, equal to `row*COLS + col`, registered.
- `key_valid`  out  1: one-cycle pulse when a press is accepted.
- `key_held`  out  1: high from acceptance until the release is accepted.

## Operation
- `row_i` passes through a 2-flop synchroniser; all decisions use the synchronised value `rs`.
- Divider `div` counts 0..SCAN_DIV-1 and wraps. The cycle with `div == SCAN_DIV-1` is a "tick" and is the only cycle in which `rs` is sampled.
- Column index `ci` (0..COLS-1, wraps COLS-1 → 0) gives `col_o = ~(1 << ci)`. `ci` advances only on a tick in SCAN with no key, or on a tick that leaves DEBOUNCE or RELEASE for SCAN.
- States and transitions:
  - SCAN, tick, any `rs` bit low: latch `cand_row` as the lowest-index low row and `cand_col = ci`. Freeze `ci`. Set `cnt = 1`. Go to DEBOUNCE. If DEBOUNCE == 1, go straight to HELD with the accept actions.
  - SCAN, tick, no row low: advance `ci`.
  - DEBOUNCE, tick, `rs[cand_row]` low: increment `cnt`. When `cnt` reaches DEBOUNCE: set `key_code`, pulse `key_valid`, set `key_held = 1`, go to HELD.
  - DEBOUNCE, tick, `rs[cand_row]` high: go to SCAN and advance `ci`. No output change.
  - HELD, tick, `rs[cand_row]` high: set `cnt = 1` and go to RELEASE. If DEBOUNCE == 1, release immediately.
  - HELD, tick, `rs[cand_row]` low: stay in HELD.
  - RELEASE, tick, `rs[cand_row]` high: increment `cnt`. When `cnt` reaches DEBOUNCE: clear `key_held`, go to SCAN, advance `ci`.
  - RELEASE, tick, `rs[cand_row]` low: return to HELD. `key_held` stays 1 and no new `key_valid` is issued.
- Multiple keys: only the candidate row in the frozen column is watched. Other keys are ignored until the release is accepted.
- `key_code` keeps its last value after release.
- Reset (asynchronous, any time, including mid-press):
  - state = SCAN, `div = 0`, `ci = 0`, `cnt = 0`, synchroniser flops all ones.
  - `col_o` = all ones except bit 0 low.
  - `key_code = 0`, `key_valid = 0`, `key_held = 0`.

## Timing
- From `row_i` to a sampled value: 2 cycles. The dwell of at least 4 cycles covers synchroniser latency plus settling.
- `key_valid` and `key_held` rise in the cycle after the accepting tick. `key_valid` is high for exactly 1 cycle.
- Minimum press-to-`key_valid`: (DEBOUNCE-1)*SCAN_DIV + 1 cycles after the first detecting tick.
- `key_held` falls in the cycle after the release-accepting tick.
- `col_o` changes in the cycle after an advancing tick and is otherwise constant.
- `cnt` needs $clog2(DEBOUNCE+1) bits; `div` needs $clog2(SCAN_DIV) bits. Neither may overflow.

## Structure
- `teclado_pkg` holds:
  - the `scan_state_t` enum: SCAN, DEBOUNCE, HELD, RELEASE;
  - a `key_code_f(row, col, COLS)` function.
- Sub-module `sync_2ff`, parametrised by width, is used for `row_i`.

## Test plan
Bench settings: COLS=4, ROWS=4, SCAN_DIV=8, DEBOUNCE=3. The bench models the matrix: a pressed row reads low only while its column is driven low.
- Reset, no keys: `col_o` = 1110, all outputs 0. Then 1110→1101→1011→0111→1110, each held 8 cycles.
- Press row 2/col 1 and hold: `col_o` freezes at 1101, `key_code` = 9, one `key_valid` pulse, `key_held` = 1.
- Bounce (press seen on 1 tick, then released): no `key_valid`, and scanning resumes at 1011.
- Release after a hold: row high for 3 ticks → `key_held` = 0 and `col_o` = 1011. A 1-tick release glitch instead leaves `key_held` at 1 with no second pulse.
- Rows 0 and 3 pressed together in col 2: `key_code` = 2.
- Assert `rst_n` low while in HELD: the reset values appear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/teclado_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package teclado_pkg;

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } scan_state_t;

  // Linear key index, row-major across the matrix.
  function automatic int key_code_f(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/barrido_teclado_if.sv
// Keypad pin / decoded-key bundle between the scanner and its neighbours.
interface barrido_teclado_if #(
  parameter int COLS = 4,
  parameter int ROWS = 4
);
  localparam int KW = $clog2(ROWS * COLS);

  logic [ROWS-1:0] row_i;
  logic [COLS-1:0] col_o;
  logic [KW-1:0]   key_code;
  logic            key_valid;
  logic            key_held;

  modport master (output row_i, input col_o, key_code, key_valid, key_held);
  modport slave  (input row_i, output col_o, key_code, key_valid, key_held);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser; resets to all ones so idle pulled-up lines read inactive.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/barrido_teclado.sv
// Keypad matrix scanner: one-cold column sweep, per-tick row sampling,
// press/release debounce and a linear key code with valid pulse and held level.
module barrido_teclado
  import teclado_pkg::*;
#(
  parameter int COLS     = 4,
  parameter int ROWS     = 4,
  parameter int SCAN_DIV = 135,
  parameter int DEBOUNCE = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  barrido_teclado_if.slave   kp
);
  localparam int KW  = $clog2(ROWS * COLS);
  localparam int DW  = $clog2(SCAN_DIV);
  localparam int CIW = $clog2(COLS);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] DB_N = CW'(DEBOUNCE);

  scan_state_t    state;
  logic [DW-1:0]  div;
  logic [CIW-1:0] ci, ci_nx, cand_col;
  logic [RW-1:0]  cand_row, low_row;
  logic [CW-1:0]  cnt;
  logic [ROWS-1:0] rs;
  logic           tick, any_low, cand_low;

  sync_2ff #(.W(ROWS)) u_sync (.clk(clk), .rst_n(rst_n), .d(kp.row_i), .q(rs));

  assign tick     = (div == DW'(SCAN_DIV - 1));
  assign ci_nx    = (ci == CIW'(COLS - 1)) ? '0 : ci + 1'b1;
  assign any_low  = ~&rs;
  assign cand_low = ~rs[cand_row];

  // Highest index scanned first so the lowest low row wins.
  always_comb begin
    low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (!rs[i]) low_row = RW'(i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_SCAN;
      div          <= '0;
      ci           <= '0;
      cnt          <= '0;
      cand_row     <= '0;
      cand_col     <= '0;
      kp.col_o     <= ~COLS'(1);
      kp.key_code  <= '0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
    end else begin
      kp.key_valid <= 1'b0;
      div          <= tick ? '0 : div + 1'b1;
      if (tick) begin
        unique case (state)
          S_SCAN: begin
            if (any_low) begin
              cand_row <= low_row;
              cand_col <= ci;
              cnt      <= CW'(1);
              if (DEBOUNCE == 1) begin
                kp.key_code  <= KW'(key_code_f(int'(low_row), int'(ci), COLS));
                kp.key_valid <= 1'b1;
                kp.key_held  <= 1'b1;
                state        <= S_HELD;
              end else begin
                state <= S_DEBOUNCE;
              end
            end else begin
              ci       <= ci_nx;
              kp.col_o <= ~(COLS'(1) << ci_nx);
            end
          end
          S_DEBOUNCE: begin
            if (cand_low) begin
              cnt <= cnt + 1'b1;
              if (cnt + 1'b1 == DB_N) begin
                kp.key_code  <= KW'(key_code_f(int'(cand_row), int'(cand_col), COLS));
                kp.key_valid <= 1'b1;
                kp.key_held  <= 1'b1;
                state        <= S_HELD;
              end
            end else begin
              state    <= S_SCAN;
              ci       <= ci_nx;
              kp.col_o <= ~(COLS'(1) << ci_nx);
            end
          end
          S_HELD: begin
            if (!cand_low) begin
              cnt <= CW'(1);
              if (DEBOUNCE == 1) begin
                kp.key_held <= 1'b0;
                state       <= S_SCAN;
                ci          <= ci_nx;
                kp.col_o    <= ~(COLS'(1) << ci_nx);
              end else begin
                state <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            if (!cand_low) begin
              cnt <= cnt + 1'b1;
              if (cnt + 1'b1 == DB_N) begin
                kp.key_held <= 1'b0;
                state       <= S_SCAN;
                ci          <= ci_nx;
                kp.col_o    <= ~(COLS'(1) << ci_nx);
              end
            end else begin
              // Glitch during release: back to held, no fresh valid pulse.
              state <= S_HELD;
            end
          end
          default: state <= S_SCAN;
        endcase
      end
    end
  end
endmodule
